// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-cycle path: default widths and the
// duty ramp state encoding.
package pwm_pkg;

    localparam int unsigned DUTY_W_DEFAULT   = 8;
    localparam int unsigned PERIOD_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/ramp_tick_gen.sv
// Step-interval counter for the duty ramp: tick marks the last clock of each
// interval of max(period,1) clocks.
module ramp_tick_gen #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                freeze,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] last;

    always_comb begin
        last = (period == '0) ? '0 : period - PERIOD_W'(1);
        // >= rather than == so a live shrink below cnt steps immediately.
        tick = (cnt >= last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (freeze) begin
            cnt <= cnt;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter on the duty-cycle path between spi_peripheral and
// pwm_peripheral; steps duty_out toward target_duty or bypasses it.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_W   = DUTY_W_DEFAULT,
    parameter int unsigned PERIOD_W = PERIOD_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DUTY_W-1:0]   target_duty,
    input  logic                ramp_en,
    input  logic [DUTY_W-1:0]   ramp_step,
    input  logic [PERIOD_W-1:0] ramp_period,
    input  logic                hold,
    output logic [DUTY_W-1:0]   duty_out,
    output logic                busy,
    output logic                done
);

    ramp_state_t       state;
    ramp_state_t       state_next;
    logic [DUTY_W-1:0] duty_next;
    logic              done_next;
    logic              cnt_clear;
    logic              cnt_freeze;
    logic              tick;
    logic              bypass;
    logic [DUTY_W:0]   sum;
    logic [DUTY_W:0]   diff;
    logic [DUTY_W-1:0] up_val;
    logic [DUTY_W-1:0] down_val;
    logic [DUTY_W-1:0] step_val;

    ramp_tick_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .freeze (cnt_freeze),
        .period (ramp_period),
        .tick   (tick)
    );

    // One extra bit catches both overflow past full scale and borrow below 0.
    always_comb begin
        sum      = {1'b0, duty_out} + {1'b0, ramp_step};
        diff     = {1'b0, duty_out} - {1'b0, ramp_step};
        up_val   = (sum >= {1'b0, target_duty}) ? target_duty : sum[DUTY_W-1:0];
        down_val = (diff[DUTY_W] || (diff[DUTY_W-1:0] <= target_duty))
                   ? target_duty : diff[DUTY_W-1:0];
        step_val = (target_duty > duty_out) ? up_val : down_val;
        bypass   = !ramp_en || (ramp_step == '0);
    end

    always_comb begin
        state_next = state;
        duty_next  = duty_out;
        done_next  = 1'b0;
        cnt_clear  = 1'b0;
        cnt_freeze = 1'b0;

        if (hold) begin
            cnt_freeze = 1'b1;
        end else if (bypass) begin
            duty_next  = target_duty;
            state_next = IDLE;
            cnt_clear  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_clear = 1'b1;
                    if (target_duty > duty_out) begin
                        state_next = UP;
                    end else if (target_duty < duty_out) begin
                        state_next = DOWN;
                    end
                end
                UP, DOWN: begin
                    // Direction follows the live target; the counter keeps running.
                    if (tick) begin
                        duty_next = step_val;
                        if (step_val == target_duty) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = (target_duty > duty_out) ? UP : DOWN;
                        end
                    end else if (target_duty == duty_out) begin
                        state_next = IDLE;
                    end else begin
                        state_next = (target_duty > duty_out) ? UP : DOWN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            duty_out <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            duty_out <= duty_next;
            done     <= done_next;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed self-checking bench for pwm_duty_ramp: a per-cycle vector table
// plus hand-written multi-cycle ramp sequences.
module tb_pwm_duty_ramp;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  target_duty;
    logic        ramp_en;
    logic [7:0]  ramp_step;
    logic [15:0] ramp_period;
    logic        hold;
    logic [7:0]  duty_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp #(
        .DUTY_W   (8),
        .PERIOD_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .target_duty (target_duty),
        .ramp_en     (ramp_en),
        .ramp_step   (ramp_step),
        .ramp_period (ramp_period),
        .hold        (hold),
        .duty_out    (duty_out),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic        r;
        logic        en;
        logic [7:0]  tgt;
        logic [7:0]  stp;
        logic [15:0] per;
        logic        hld;
        logic [7:0]  e_duty;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[15];

    task automatic drive(input logic r, input logic en, input logic [7:0] tgt,
                         input logic [7:0] stp, input logic [15:0] per, input logic hld);
        rst         = r;
        ramp_en     = en;
        target_duty = tgt;
        ramp_step   = stp;
        ramp_period = per;
        hold        = hld;
    endtask

    task automatic edge_check(input string name, input logic [7:0] e_duty,
                              input logic e_busy, input logic e_done);
        @(posedge clk);
        #1;
        checks++;
        if (duty_out !== e_duty) begin
            errors++;
            $display("FAIL %s duty_out: got %0d expected %0d", name, duty_out, e_duty);
        end
        checks++;
        if (busy !== e_busy) begin
            errors++;
            $display("FAIL %s busy: got %b expected %b", name, busy, e_busy);
        end
        checks++;
        if (done !== e_done) begin
            errors++;
            $display("FAIL %s done: got %b expected %b", name, done, e_done);
        end
    endtask

    // Ramp 0 -> 100, step 10, period 4; optional hold window over edges hold_lo..hold_hi.
    task automatic run_ramp100(input string name, input int hold_lo, input int hold_hi);
        int n_hold;
        int eff;
        int exp_d;
        n_hold = (hold_hi >= hold_lo) ? (hold_hi - hold_lo + 1) : 0;
        drive(1'b0, 1'b0, 8'd0, 8'd10, 16'd4, 1'b0);
        edge_check({name, "_pre"}, 8'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd100, 8'd10, 16'd4, 1'b0);
        edge_check({name, "_start"}, 8'd0, 1'b1, 1'b0);
        for (int e = 1; e <= 41 + n_hold; e++) begin
            hold = (e >= hold_lo && e <= hold_hi);
            if (e < hold_lo)       eff = e;
            else if (e <= hold_hi) eff = hold_lo - 1;
            else                   eff = e - n_hold;
            exp_d = 10 * (eff / 4);
            if (exp_d > 100) exp_d = 100;
            edge_check(name, 8'(exp_d), eff < 40, eff == 40);
        end
        hold = 1'b0;
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'h33, 8'd0, 16'd0, 1'b0);

        //            r     en    tgt    stp    per    hld   duty   busy  done
        vecs[0]  = '{1'b1, 1'b0, 8'h33, 8'd10, 16'd4, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h80, 8'd10, 16'd4, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h12, 8'd10, 16'd4, 1'b0, 8'h12, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h40, 8'd0,  16'd4, 1'b0, 8'h40, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h40, 8'd16, 16'd1, 1'b0, 8'h40, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h45, 8'd16, 16'd1, 1'b0, 8'h40, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h45, 8'd16, 16'd1, 1'b0, 8'h45, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h45, 8'd16, 16'd1, 1'b0, 8'h45, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h20, 8'd16, 16'd0, 1'b0, 8'h45, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h20, 8'd16, 16'd0, 1'b0, 8'h35, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h20, 8'd16, 16'd0, 1'b0, 8'h25, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'h20, 8'd16, 16'd0, 1'b0, 8'h20, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 8'h20, 8'd16, 16'd0, 1'b0, 8'h20, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h99, 8'd16, 16'd0, 1'b1, 8'h20, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h99, 8'd16, 16'd0, 1'b0, 8'h99, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].r, vecs[i].en, vecs[i].tgt, vecs[i].stp, vecs[i].per, vecs[i].hld);
            edge_check($sformatf("vec%0d", i), vecs[i].e_duty, vecs[i].e_busy, vecs[i].e_done);
        end

        run_ramp100("ramp100", 1000, 999);
        run_ramp100("hold7", 7, 13);

        // Saturation at full scale and at zero.
        drive(1'b0, 1'b0, 8'd250, 8'd16, 16'd1, 1'b0);
        edge_check("sat_hi_pre", 8'd250, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd255, 8'd16, 16'd1, 1'b0);
        edge_check("sat_hi_start", 8'd250, 1'b1, 1'b0);
        edge_check("sat_hi_step", 8'd255, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'd5, 8'd16, 16'd1, 1'b0);
        edge_check("sat_lo_pre", 8'd5, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd0, 8'd16, 16'd1, 1'b0);
        edge_check("sat_lo_start", 8'd5, 1'b1, 1'b0);
        edge_check("sat_lo_step", 8'd0, 1'b0, 1'b1);

        // Reversal at 40 while ramping up to 100.
        drive(1'b0, 1'b0, 8'd0, 8'd10, 16'd4, 1'b0);
        edge_check("rev_pre", 8'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd100, 8'd10, 16'd4, 1'b0);
        edge_check("rev_start", 8'd0, 1'b1, 1'b0);
        for (int e = 1; e <= 16; e++) begin
            edge_check("rev_up", 8'(10 * (e / 4)), 1'b1, 1'b0);
        end
        target_duty = 8'd20;
        for (int j = 1; j <= 9; j++) begin
            edge_check("rev_down", (j < 4) ? 8'd40 : ((j < 8) ? 8'd30 : 8'd20), j < 8, j == 8);
        end

        // Reset mid-ramp, then a fresh start from 0.
        drive(1'b0, 1'b0, 8'd0, 8'd10, 16'd4, 1'b0);
        edge_check("rst_pre", 8'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'd100, 8'd10, 16'd4, 1'b0);
        edge_check("rst_start", 8'd0, 1'b1, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            edge_check("rst_ramp", 8'(10 * (e / 4)), 1'b1, 1'b0);
        end
        rst = 1'b1;
        edge_check("rst_mid", 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        edge_check("rst_restart", 8'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Slew-rate limiter inserted between `spi_peripheral` and `pwm_peripheral` on the duty-cycle path. It takes the SPI-written target duty and drives `pwm_peripheral`'s `pwm_duty_cycle` input. Instead of jumping to a new target, it steps toward it by a programmable increment once every programmable number of clocks, so outputs see no abrupt duty changes. Bypass mode passes the target straight through with one cycle of latency.

## Interface
- `DUTY_W`, 8: duty-cycle width.
- `PERIOD_W`, 16: width of the step-interval counter.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high. The top level drives it as `~rst_n`.
- `target_duty`  in  DUTY_W  requested duty, taken from the SPI register.
- `ramp_en`  in  1  1 = slew-limited, 0 = bypass.
- `ramp_step`  in  DUTY_W  increment per step; 0 forces bypass.
- `ramp_period`  in  PERIOD_W  clocks between steps; 0 is treated as 1.
- `hold`  in  1  freezes both `duty_out` and the interval counter.
- `duty_out`  out  DUTY_W  duty sent to `pwm_peripheral`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a ramp lands on its target.

## Operation
- States:
  - IDLE: no ramp in progress.
  - UP: stepping `duty_out` upward.
  - DOWN: stepping `duty_out` downward.
- Bypass applies when `ramp_en`=0 or `ramp_step`=0:
  - `duty_out` <= `target_duty` on every edge.
  - State forced to IDLE, counter cleared, `done`=0.
  - Entering bypass mid-ramp aborts the ramp with no `done` pulse.
- IDLE, when not in bypass:
  - `target_duty` > `duty_out` → UP, with `cnt` cleared to 0.
  - `target_duty` < `duty_out` → DOWN, with `cnt` cleared to 0.
  - `target_duty` = `duty_out` → stay in IDLE.
- UP and DOWN, each edge:
  - If `cnt` = P−1 (P = max(`ramp_period`,1)), take a step and set `cnt`=0.
  - Otherwise `cnt`++.
- Step arithmetic is done at DUTY_W+1 bits.
  - UP: `duty_out` <= min(`duty_out`+`ramp_step`, `target_duty`). The result never wraps past 255.
  - DOWN: if `duty_out` < `ramp_step`, or `duty_out`−`ramp_step` ≤ `target_duty`, the result is `target_duty`; otherwise it is `duty_out`−`ramp_step`. The result never underflows.
- When a step lands exactly on target:
  - State → IDLE.
  - `done` is registered high for exactly one cycle.
- Target is re-evaluated every cycle, including mid-ramp:
  - If direction reverses (e.g. in UP with target now < `duty_out`), switch to DOWN without restarting `cnt`.
  - If target equals `duty_out` while not on a step edge, go to IDLE with no `done` pulse.
- `ramp_step` and `ramp_period` are sampled live. Shrinking `ramp_period` below `cnt`+1 causes a step on the next edge; there is no wrap through the full counter range.
- `hold`=1 freezes `duty_out`, `cnt` and state, and keeps `done`=0. `hold` has priority over bypass.
- `rst` has priority over everything. It may assert mid-ramp and takes effect on the next edge.

## Timing
- Reset values: `duty_out`=0, `busy`=0, `done`=0, state IDLE, `cnt`=0.
- All outputs are registered; there are no combinational paths from input to output.
- Bypass latency: `target_duty` sampled at edge k is visible on `duty_out` after edge k.
- Ramp start: the edge k where IDLE sees a difference makes `busy`=1 after k. Step updates then occur at edges k+P, k+2P, …
- Total ramp time: ceil(|Δ| / `ramp_step`) × P clocks after edge k.
- `done` is high for the single cycle following the final step edge. `busy` falls on that same edge.

## Structure
- Shared package `pwm_pkg` holds:
  - DUTY_W and PERIOD_W defaults.
  - The state enum `ramp_state_t` {IDLE, UP, DOWN}.
- Sub-module `ramp_tick_gen` contains the interval counter.
  - Inputs: `clear`, `freeze`, `period`.
  - Output: `tick`, asserted when `cnt` = P−1.
- The FSM and saturating arithmetic live in `pwm_duty_ramp`.
- At the top level, the block is inserted between `spi_peripheral.pwm_duty_cycle` and `pwm_peripheral.pwm_duty_cycle`.

## Test plan
- Reset, then bypass (`ramp_en`=0), target 0x80 at edge k → `duty_out`=0x80 after k; `busy`=0 throughout.
- Start 0, target 100, step 10, period 4 → `duty_out` goes 10, 20, …, 100 at edges k+4, k+8, …, k+40; single `done` pulse after k+40.
- Start 250, target 255, step 16, period 1 → one step to 255 with no wrap. Start 5, target 0, step 16 → one step to 0 with no underflow.
- Mid-ramp reversal: at 40 while ramping up to 100, set target 20 → state DOWN, `duty_out` steps down to 20 without passing through IDLE; `done` pulses once, at 20.
- Assert `hold` for 7 cycles mid-ramp → `duty_out` and `cnt` frozen; the schedule resumes shifted by exactly 7 cycles.
- Assert `rst` mid-ramp → after that edge `duty_out`=0, `busy`=0, `done`=0. Period 0 behaves identically to period 1.
